// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-select encoding,
// scoreboard entry layout and default widths.
package pipe_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned RA_W_DEF  = 5;
    localparam int unsigned RA_W_MAX  = 8;

    typedef enum logic [2:0] {
        FWD_RF = 3'd0,
        FWD_S0 = 3'd1,
        FWD_S1 = 3'd2,
        FWD_S2 = 3'd3,
        FWD_S3 = 3'd4,
        FWD_S4 = 3'd5,
        FWD_S5 = 3'd6
    } fwd_sel_t;

    // rd is stored at the widest supported register-address width
    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                regwr;
        logic                is_load;
    } sb_entry_t;

    function automatic fwd_sel_t fwd_from_idx(input logic [2:0] idx);
        return fwd_sel_t'(idx + 3'd1);
    endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Per-operand priority encoder: finds the youngest in-flight writer of a source
// register and reports its stage index, select code and load flag.
module hazard_match
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned RA_W  = RA_W_DEF
) (
    input  sb_entry_t [DEPTH-1:0] entries,
    input  logic [RA_W-1:0]       src,
    input  logic                  use_src,
    output fwd_sel_t              sel,
    output logic                  hit,
    output logic [2:0]            hit_idx,
    output logic                  hit_load
);

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_load = 1'b0;
        // ascending scan, first match kept: lowest index is the youngest producer
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit && entries[k].valid && entries[k].regwr && use_src &&
                src != '0 && entries[k].rd == RA_W_MAX'(src)) begin
                hit      = 1'b1;
                hit_idx  = 3'(k);
                hit_load = entries[k].is_load;
            end
        end
        sel = hit ? fwd_from_idx(hit_idx) : FWD_RF;
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Data-hazard forwarding, load-use stall and branch-redirect flush control
// driven by a shift-register scoreboard of in-flight instructions.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned RA_W     = RA_W_DEF,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_IDX = 1,
    parameter int unsigned BR_IDX   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [RA_W-1:0]       id_rs,
    input  logic [RA_W-1:0]       id_rt,
    input  logic                  id_use_rs,
    input  logic                  id_use_rt,
    input  logic [RA_W-1:0]       id_rd,
    input  logic                  id_regwr,
    input  logic                  id_is_load,
    input  logic [XLEN-1:0]       rf_a,
    input  logic [XLEN-1:0]       rf_b,
    input  logic [DEPTH*XLEN-1:0] stage_res,
    input  logic                  redirect,
    input  logic                  hold,
    output logic [XLEN-1:0]       opa,
    output logic [XLEN-1:0]       opb,
    output logic [2:0]            sel_a,
    output logic [2:0]            sel_b,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    sb_entry_t [DEPTH-1:0] sb;
    fwd_sel_t              sel_rs, sel_rt;
    logic                  hit_rs, hit_rt, load_rs, load_rt;
    logic [2:0]            idx_rs, idx_rt;
    logic                  load_use;
    logic [31:0]           stall_cnt_q, flush_cnt_q;

    hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_rs (
        .entries (sb),
        .src     (id_rs),
        .use_src (id_use_rs),
        .sel     (sel_rs),
        .hit     (hit_rs),
        .hit_idx (idx_rs),
        .hit_load(load_rs)
    );

    hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_rt (
        .entries (sb),
        .src     (id_rt),
        .use_src (id_use_rt),
        .sel     (sel_rt),
        .hit     (hit_rt),
        .hit_idx (idx_rt),
        .hit_load(load_rt)
    );

    assign load_use = (hit_rs && load_rs && 32'(idx_rs) < LOAD_IDX) ||
                      (hit_rt && load_rt && 32'(idx_rt) < LOAD_IDX);

    always_comb begin
        opa = rf_a;
        opb = rf_b;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (hit_rs && idx_rs == 3'(k)) opa = stage_res[k*XLEN +: XLEN];
            if (hit_rt && idx_rt == 3'(k)) opb = stage_res[k*XLEN +: XLEN];
        end
    end

    assign sel_a     = rst_n ? sel_rs : FWD_RF;
    assign sel_b     = rst_n ? sel_rt : FWD_RF;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (hold) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (redirect) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_idex = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb          <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!hold) begin
            sb[0] <= '{valid:   id_valid && !load_use && !redirect,
                       rd:      RA_W_MAX'(id_rd),
                       regwr:   id_regwr,
                       is_load: id_is_load};
            // wrong-path instructions younger than the branch are squashed as they shift
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sb[k] <= sb[k-1];
                if (redirect && (k - 1) < BR_IDX) sb[k].valid <= 1'b0;
            end
            if (redirect && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (load_use && !redirect && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: directed pipeline scenarios plus
// randomized traffic checked against a queue-based pipeline model.
module tb_pipe_hazard_unit;

    localparam int XLEN     = 32;
    localparam int RA_W     = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_IDX = 1;
    localparam int BR_IDX   = 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  id_valid, id_use_rs, id_use_rt, id_regwr, id_is_load;
    logic [RA_W-1:0]       id_rs, id_rt, id_rd;
    logic [XLEN-1:0]       rf_a, rf_b;
    logic [DEPTH*XLEN-1:0] stage_res;
    logic                  redirect, hold;
    logic [XLEN-1:0]       opa, opb;
    logic [2:0]            sel_a, sel_b;
    logic                  pc_en, ifid_en, flush_ifid, flush_idex;
    logic [31:0]           stall_cnt, flush_cnt;

    pipe_hazard_unit #(
        .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_IDX(LOAD_IDX), .BR_IDX(BR_IDX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_regwr(id_regwr),
        .id_is_load(id_is_load), .rf_a(rf_a), .rf_b(rf_b), .stage_res(stage_res),
        .redirect(redirect), .hold(hold), .opa(opa), .opb(opb), .sel_a(sel_a), .sel_b(sel_b),
        .pc_en(pc_en), .ifid_en(ifid_en), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                  id_valid, use_rs, use_rt, regwr, is_load, redirect, hold;
        logic [4:0]            rs, rt, rd;
        logic [31:0]           rf_a, rf_b;
        logic [DEPTH*XLEN-1:0] res;
    } stim_t;

    typedef struct {
        logic [31:0] opa, opb, stall_cnt, flush_cnt;
        logic [2:0]  sel_a, sel_b;
        logic        pc_en, ifid_en, fl_ifid, fl_idex;
    } exp_t;

    typedef struct { bit v; bit [4:0] rd; bit wr; bit ld; } ins_t;

    ins_t   pipe[$];          // pipe[0] is the instruction in EX
    exp_t   exp_q[$];
    longint m_stall, m_flush;
    stim_t  cur;
    bit     cur_live;
    exp_t   last_exp;
    int     checks = 0;
    int     failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endfunction

    // youngest older instruction that writes r, or -1 when the register file supplies it
    function automatic int producer(input logic [4:0] r, input logic used);
        if (!used || r == 5'd0) return -1;
        for (int i = 0; i < pipe.size(); i++)
            if (pipe[i].v && pipe[i].wr && pipe[i].rd == r) return i;
        return -1;
    endfunction

    function automatic bit load_hazard(input stim_t s);
        int pa = producer(s.rs, s.use_rs);
        int pb = producer(s.rt, s.use_rt);
        return (pa >= 0 && pa < LOAD_IDX && pipe[pa].ld) || (pb >= 0 && pb < LOAD_IDX && pipe[pb].ld);
    endfunction

    function automatic exp_t expect_of(input stim_t s);
        exp_t e;
        int pa = producer(s.rs, s.use_rs);
        int pb = producer(s.rt, s.use_rt);
        bit lu = load_hazard(s);
        e.sel_a = (pa < 0) ? 3'd0 : 3'(pa + 1);
        e.sel_b = (pb < 0) ? 3'd0 : 3'(pb + 1);
        e.opa   = (pa < 0) ? s.rf_a : s.res[pa*XLEN +: XLEN];
        e.opb   = (pb < 0) ? s.rf_b : s.res[pb*XLEN +: XLEN];
        if (s.hold)          {e.pc_en, e.ifid_en, e.fl_ifid, e.fl_idex} = 4'b0000;
        else if (s.redirect) {e.pc_en, e.ifid_en, e.fl_ifid, e.fl_idex} = 4'b1111;
        else if (lu)         {e.pc_en, e.ifid_en, e.fl_ifid, e.fl_idex} = 4'b0001;
        else                 {e.pc_en, e.ifid_en, e.fl_ifid, e.fl_idex} = 4'b1100;
        e.stall_cnt = 32'(m_stall);
        e.flush_cnt = 32'(m_flush);
        return e;
    endfunction

    function automatic void advance(input stim_t s);
        bit   lu;
        ins_t n;
        if (s.hold) return;
        lu = load_hazard(s);
        if (s.redirect) begin
            for (int i = 0; i < BR_IDX; i++) pipe[i].v = 1'b0;
            if (m_flush < 64'hFFFF_FFFF) m_flush++;
        end else if (lu) begin
            if (m_stall < 64'hFFFF_FFFF) m_stall++;
        end
        n = '{v: s.id_valid && !lu && !s.redirect, rd: s.rd, wr: s.regwr, ld: s.is_load};
        pipe.push_front(n);
        void'(pipe.pop_back());
    endfunction

    function automatic void model_reset();
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back('{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0});
        m_stall = 0;
        m_flush = 0;
    endfunction

    function automatic stim_t ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic urs, input logic urt, input logic [4:0] rd,
                                  input logic wr, input logic ld);
        stim_t s;
        s.id_valid = v;  s.rs = rs;  s.rt = rt;  s.use_rs = urs;  s.use_rt = urt;
        s.rd = rd;  s.regwr = wr;  s.is_load = ld;
        s.rf_a = $urandom;  s.rf_b = $urandom;
        for (int k = 0; k < DEPTH; k++) s.res[k*XLEN +: XLEN] = $urandom;
        s.redirect = 1'b0;  s.hold = 1'b0;
        return s;
    endfunction

    function automatic stim_t idle();
        return ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endfunction

    // a stalled or held decode keeps its instruction; a held redirect stays asserted
    function automatic stim_t rnd(input stim_t prev, input exp_t pe);
        stim_t s;
        s = ins(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        if (!pe.ifid_en) begin
            s.id_valid = prev.id_valid;  s.rs = prev.rs;  s.rt = prev.rt;
            s.use_rs = prev.use_rs;  s.use_rt = prev.use_rt;  s.rd = prev.rd;
            s.regwr = prev.regwr;  s.is_load = prev.is_load;
        end
        s.hold     = ($urandom_range(0, 9) == 0);
        s.redirect = (prev.redirect && prev.hold) ? 1'b1 : ($urandom_range(0, 11) == 0);
        return s;
    endfunction

    task automatic apply(input stim_t s);
        id_valid = s.id_valid;  id_rs = s.rs;  id_rt = s.rt;
        id_use_rs = s.use_rs;  id_use_rt = s.use_rt;  id_rd = s.rd;
        id_regwr = s.regwr;  id_is_load = s.is_load;
        rf_a = s.rf_a;  rf_b = s.rf_b;  stage_res = s.res;
        redirect = s.redirect;  hold = s.hold;
    endtask

    task automatic cycle(input stim_t s);
        @(posedge clk);
        if (cur_live) advance(cur);
        #1;
        cur = s;
        cur_live = 1'b1;
        apply(s);
        last_exp = expect_of(s);
        exp_q.push_back(last_exp);
        #1;
    endtask

    task automatic reset_checks();
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_ifid_en", 32'(ifid_en), 32'd0);
        chk("rst_flush_ifid", 32'(flush_ifid), 32'd1);
        chk("rst_flush_idex", 32'(flush_idex), 32'd1);
        chk("rst_sel_a", 32'(sel_a), 32'd0);
        chk("rst_sel_b", 32'(sel_b), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_flush_cnt", flush_cnt, 32'd0);
    endtask

    task automatic do_reset();
        stim_t s = idle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        cur_live = 1'b0;
        apply(s);
        @(posedge clk);
        @(negedge clk);
        cur = s;
        cur_live = 1'b1;
        last_exp = expect_of(s);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("opa", opa, e.opa);
                chk("opb", opb, e.opb);
                chk("sel_a", 32'(sel_a), 32'(e.sel_a));
                chk("sel_b", 32'(sel_b), 32'(e.sel_b));
                chk("pc_en", 32'(pc_en), 32'(e.pc_en));
                chk("ifid_en", 32'(ifid_en), 32'(e.ifid_en));
                chk("flush_ifid", 32'(flush_ifid), 32'(e.fl_ifid));
                chk("flush_idex", 32'(flush_idex), 32'(e.fl_idex));
                chk("stall_cnt", stall_cnt, e.stall_cnt);
                chk("flush_cnt", flush_cnt, e.flush_cnt);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    budget;
        rst_n = 1'b0;
        cur_live = 1'b0;
        apply(idle());
        #3;
        reset_checks();
        model_reset();
        @(negedge clk);
        cur = idle();
        cur_live = 1'b1;
        rst_n = 1'b1;

        // add r3,r1,r2 ; sub r4,r3,r5 -> EX forward
        cycle(ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0));
        cycle(ins(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0));
        chk("ex_fwd_sel_a", 32'(sel_a), 32'd1);
        chk("ex_fwd_opa", opa, cur.res[31:0]);
        chk("ex_fwd_pc_en", 32'(pc_en), 32'd1);

        // lw r3 ; add r4,r3,r3 -> one stall then MEM forward
        cycle(ins(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1));
        s = ins(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
        cycle(s);
        chk("lu_pc_en", 32'(pc_en), 32'd0);
        chk("lu_flush_idex", 32'(flush_idex), 32'd1);
        cycle(s);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        chk("lu_sel_a", 32'(sel_a), 32'd2);
        chk("lu_sel_b", 32'(sel_b), 32'd2);
        chk("lu_resolved_pc_en", 32'(pc_en), 32'd1);

        // r3 written in EX and WB -> youngest wins; r0 never forwarded
        cycle(ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0));
        cycle(ins(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0));
        cycle(ins(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0));
        cycle(ins(1, 5'd3, 5'd7, 1, 1, 5'd9, 1, 0));
        chk("youngest_sel_a", 32'(sel_a), 32'd1);
        chk("youngest_sel_b", 32'(sel_b), 32'd2);
        cycle(ins(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0));
        cycle(ins(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0));
        chk("r0_sel_a", 32'(sel_a), 32'd0);
        chk("r0_opa", opa, cur.rf_a);

        // load in EX with redirect in the same cycle -> flush, no stall
        cycle(ins(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1));
        s = ins(1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
        s.redirect = 1'b1;
        cycle(s);
        chk("redir_pc_en", 32'(pc_en), 32'd1);
        chk("redir_flush_ifid", 32'(flush_ifid), 32'd1);
        chk("redir_flush_idex", 32'(flush_idex), 32'd1);
        cycle(idle());
        chk("redir_flush_cnt", flush_cnt, 32'd1);
        chk("redir_stall_cnt", stall_cnt, 32'd1);

        // hold for 4 cycles across a load-use
        cycle(ins(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1));
        s = ins(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0);
        s.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(s);
            chk("hold_pc_en", 32'(pc_en), 32'd0);
            chk("hold_flush_idex", 32'(flush_idex), 32'd0);
            chk("hold_sel_a", 32'(sel_a), 32'd1);
            chk("hold_stall_cnt", stall_cnt, 32'd1);
        end
        s.hold = 1'b0;
        cycle(s);
        chk("unhold_pc_en", 32'(pc_en), 32'd0);
        chk("unhold_flush_idex", 32'(flush_idex), 32'd1);
        cycle(s);
        chk("unhold_sel_a", 32'(sel_a), 32'd2);
        chk("unhold_stall_cnt", stall_cnt, 32'd2);

        // flush counter saturation
        @(negedge clk);
        #1;
        force dut.flush_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.flush_cnt_q;
        m_flush = 64'hFFFF_FFFF;
        cycle(idle());
        s = idle();
        s.redirect = 1'b1;
        cycle(s);
        cycle(idle());
        chk("sat_flush_cnt", flush_cnt, 32'hFFFF_FFFF);

        // reset in the middle of a load-use stall
        cycle(ins(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1));
        s = ins(1, 5'd3, 5'd0, 1, 0, 5'd4, 1, 0);
        cycle(s);
        chk("prerst_pc_en", 32'(pc_en), 32'd0);
        do_reset();
        cycle(s);
        chk("postrst_sel_a", 32'(sel_a), 32'd0);
        chk("postrst_pc_en", 32'(pc_en), 32'd1);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            s = rnd(cur, last_exp);
            cycle(s);
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            #1;
            budget++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
